// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller slice.
package sevenseg_pkg;

   localparam int CODE_W = 5;
   localparam int SEG_W  = 7;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // One counter serves both phases, so it must hold the larger of the two lengths.
   function automatic int timer_width(input int slot_cycles, input int blank_cycles);
      int longest;
      longest = (slot_cycles > blank_cycles) ? slot_cycles : blank_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Frame-load handshake between the result logic (master) and the scan controller (slave).
interface sevenseg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
   import sevenseg_pkg::*;

   logic                         load_valid;
   logic                         load_ready;
   logic [CODE_W*NUM_DIGITS-1:0] load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/sevenseg_scan_ctrl_timer.sv
// Shared phase timer: reloads on every phase change, tc marks the last cycle of a phase.
module scan_slot_timer
   import sevenseg_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int CNT_W        = timer_width(SLOT_CYCLES, BLANK_CYCLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  scan_state_e      state,
   output logic             tc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] SLOT_LD  = CNT_W'(SLOT_CYCLES);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);

   // A cleared counter (after reset) first loads the current phase, which adds one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (count == '0) begin
         count <= (state == ST_SHOW) ? SLOT_LD : BLANK_LD;
      end else if (tc) begin
         count <= (state == ST_SHOW) ? BLANK_LD : SLOT_LD;
      end else begin
         count <= count - CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits with tear-free frame swap.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits (above digit 0) dark.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter  int NUM_DIGITS   = 4,
   parameter  int SLOT_CYCLES  = 50000,
   parameter  int BLANK_CYCLES = 16,
   localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sevenseg_scan_ctrl_if.slave   load,
   output logic [CODE_W-1:0]     code_out,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [IDX_W-1:0]      digit_idx,
   output logic                  frame_start
);

   localparam int CNT_W = timer_width(SLOT_CYCLES, BLANK_CYCLES);

   scan_state_e                          state_q, state_d;
   logic [NUM_DIGITS-1:0][CODE_W-1:0]    frame_q, pend_q;
   logic                                 pending_q;
   logic [CODE_W-1:0]                    code_q;
   logic [IDX_W-1:0]                     idx_q;
   logic                                 tc;
   logic [CNT_W-1:0]                     count;
   logic                                 swap;
   logic                                 lit;

   scan_slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .state(state_q),
      .tc   (tc),
      .count(count)
   );

   // The pending frame only replaces the shown one as digit 0 is about to light.
   assign swap             = (state_q == ST_BLANK) && tc && (idx_q == '0) && pending_q;
   assign load.load_ready  = ~pending_q;
   assign digit_idx        = idx_q;

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] nz_from;
   logic                  nz_acc;

   always_comb begin
      nz_acc  = 1'b0;
      nz_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_acc     = nz_acc | (frame_q[i] != '0);
         nz_from[i] = nz_acc;
      end
   end

   assign lit = (idx_q == '0) || nz_from[idx_q];
`else
   assign lit = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   // Buffers, handshake and scan index; a full pending buffer blocks further loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q   <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         code_q    <= '0;
         idx_q     <= '0;
      end else begin
         code_q <= code_out;
         if (swap) begin
            frame_q <= pend_q;
         end
         if (load.load_valid && !pending_q) begin
            pend_q    <= load.load_data;
            pending_q <= 1'b1;
         end else if (swap) begin
            pending_q <= 1'b0;
         end
         if ((state_q == ST_SHOW) && tc) begin
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   // The next code is presented in the last blank cycle so the decoder settles before lighting.
   always_comb begin
      state_d     = state_q;
      an_n        = '1;
      frame_start = 1'b0;
      code_out    = code_q;
      case (state_q)
         ST_BLANK: begin
            if (tc) begin
               state_d  = ST_SHOW;
               code_out = ((idx_q == '0) && pending_q) ? pend_q[0] : frame_q[idx_q];
            end
         end
         ST_SHOW: begin
            if (lit) begin
               an_n[idx_q] = 1'b0;
            end
            frame_start = (idx_q == '0) && (count == CNT_W'(SLOT_CYCLES));
            if (tc) begin
               state_d = ST_BLANK;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench: 4-digit scan (SLOT=8, BLANK=2) plus a 3-digit wrap-check instance.
module tb_sevenseg_scan_ctrl;
   import sevenseg_pkg::*;

   localparam int ND    = 4;
   localparam int SL    = 8;
   localparam int BL    = 2;
   localparam int PER   = SL + BL;
   localparam int FRAME = ND * PER;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) ld();
   sevenseg_scan_ctrl_if #(.NUM_DIGITS(3))  ld3();

   logic [4:0] code_out;
   logic [3:0] an_n;
   logic [1:0] digit_idx;
   logic       frame_start;

   logic [4:0] code3;
   logic [2:0] an3;
   logic [1:0] idx3;
   logic       fs3;

   sevenseg_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYCLES(SL), .BLANK_CYCLES(BL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ld.slave),
      .code_out   (code_out),
      .an_n       (an_n),
      .digit_idx  (digit_idx),
      .frame_start(frame_start)
   );

   sevenseg_scan_ctrl #(.NUM_DIGITS(3), .SLOT_CYCLES(3), .BLANK_CYCLES(1)) dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ld3.slave),
      .code_out   (code3),
      .an_n       (an3),
      .digit_idx  (idx3),
      .frame_start(fs3)
   );

   int errors = 0;
   int checks = 0;
   int k      = 0;
   int wraps  = 0;

   logic [3:0][4:0] exp_frame;
   logic [3:0][4:0] tb_pend_data;
   bit              tb_pending;
   logic [2:0]      prev_an3;
   logic [4:0]      prev_code3;
   logic [1:0]      prev_idx3;

   // Sample k is taken 1 time unit after the k-th rising edge following reset release.
   function automatic bit in_show(input int kk);
      return (kk >= 3) && (((kk - 3) % PER) < SL);
   endfunction

   function automatic bit last_blank(input int kk);
      return (kk == 2) || ((kk >= 3) && (((kk - 3) % PER) == PER - 1));
   endfunction

   function automatic int exp_idx(input int kk);
      return (kk < 3) ? 0 : (((kk - 3 + BL) / PER) % ND);
   endfunction

   function automatic bit digit_lit(input int d);
`ifdef LEADING_ZERO_BLANK_EN
      bit any_nz;
      any_nz = 1'b0;
      for (int j = d; j < ND; j++) begin
         if (exp_frame[j] != 5'd0) any_nz = 1'b1;
      end
      return (d == 0) || any_nz;
`else
      return (d >= 0);
`endif
   endfunction

   function automatic logic [3:0] exp_an(input int kk);
      logic [3:0] one;
      one = 4'b0001;
      if (in_show(kk) && digit_lit(exp_idx(kk))) return ~(one << exp_idx(kk));
      return 4'b1111;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s at k=%0d: observed=%0h expected=%0h", tag, k, obs, expv);
      end
   endtask

   task automatic check_output();
      int nxt;
      check_val("an_n", 32'(an_n), 32'(exp_an(k)));
      check_val("digit_idx", 32'(digit_idx), 32'(exp_idx(k)));
      check_val("frame_start", 32'(frame_start), 32'((k >= 3) && (((k - 3) % FRAME) == 0)));
      check_val("load_ready", 32'(ld.load_ready), 32'(!tb_pending));
      if (in_show(k)) begin
         check_val("code_show", 32'(code_out), 32'(exp_frame[exp_idx(k)]));
      end
      if (last_blank(k)) begin
         nxt = exp_idx(k);
         check_val("code_preblank", 32'(code_out),
                   32'(((nxt == 0) && tb_pending) ? tb_pend_data[0] : exp_frame[nxt]));
      end
      check_val("an3_onecold", 32'($countones(~an3) <= 1), 32'(1));
      if ((prev_an3 != 3'b111) && (an3 == prev_an3)) begin
         check_val("code3_stable_lit", 32'(code3), 32'(prev_code3));
      end
      if (idx3 != prev_idx3) begin
         check_val("idx3_step", 32'(idx3), 32'((prev_idx3 == 2'd2) ? 0 : prev_idx3 + 2'd1));
         if (idx3 == 2'd0) wraps++;
      end
      prev_an3   = an3;
      prev_code3 = code3;
      prev_idx3  = idx3;
   endtask

   // One clock of stimulus: the bench tracks the pending frame and the digit-0 swap itself.
   task automatic apply_stimulus();
      bit was_pending;
      bit xfer;
      was_pending = tb_pending;
      xfer        = ld.load_valid && !was_pending;
      @(posedge clk);
      #1;
      k++;
      if ((k >= 3) && (((k - 3) % FRAME) == 0) && was_pending) begin
         exp_frame  = tb_pend_data;
         tb_pending = 1'b0;
      end
      if (xfer) begin
         tb_pend_data = ld.load_data;
         tb_pending   = 1'b1;
      end
      check_output();
   endtask

   task automatic run_to(input int target);
      while (k < target) apply_stimulus();
   endtask

   task automatic offer(input logic [19:0] data);
      ld.load_valid = 1'b1;
      ld.load_data  = data;
      apply_stimulus();
      ld.load_valid = 1'b0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      k          = 0;
      exp_frame  = '0;
      tb_pending = 1'b0;
      prev_an3   = 3'b111;
      prev_code3 = 5'd0;
      prev_idx3  = 2'd0;
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_an_n"}, 32'(an_n), 32'(4'b1111));
      check_val({tag, "_code_out"}, 32'(code_out), 32'(0));
      check_val({tag, "_digit_idx"}, 32'(digit_idx), 32'(0));
      check_val({tag, "_frame_start"}, 32'(frame_start), 32'(0));
      check_val({tag, "_load_ready"}, 32'(ld.load_ready), 32'(1));
      check_val({tag, "_an3"}, 32'(an3), 32'(3'b111));
   endtask

   initial begin
      ld.load_valid  = 1'b0;
      ld.load_data   = '0;
      ld3.load_valid = 1'b1;
      ld3.load_data  = {5'd7, 5'd4, 5'd1};
      exp_frame      = '0;
      tb_pend_data   = '0;
      tb_pending     = 1'b0;

      #1;
      check_reset_values("rst");
      release_reset();

      // Power-up scan pattern and first frame_start.
      run_to(45);

      // Load {3,2,1,0}; a second offer while pending must be ignored.
      offer({5'd3, 5'd2, 5'd1, 5'd0});
      offer({5'd7, 5'd7, 5'd7, 5'd7});
      run_to(90);

      // Load after the swap, shown one frame later; stop inside the digit-2 slot.
      offer({5'd9, 5'd8, 5'd7, 5'd6});
      run_to(145);
      check_val("pre_reset_an_n", 32'(an_n), 32'(4'b1011));
      check_val("pre_reset_code", 32'(code_out), 32'(8));

      // Asynchronous reset with no clock edge in between.
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      release_reset();
      run_to(45);

      // Leading-zero patterns (dark digits only when the macro is built in).
      offer({5'd0, 5'd0, 5'd5, 5'd0});
      run_to(125);
      offer({5'd0, 5'd0, 5'd0, 5'd0});
      run_to(205);

      check_val("dut3_wrapped", 32'(wraps >= 2), 32'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
